uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434; clk cycles per serial bit, legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8; data bits per frame, legal range 5..9.
REQ-003 Parameter STOP_BITS, default 1; stop bits per frame, legal values 1 or 2.
REQ-004 Parameter FIFO_DEPTH, default 16; transmit buffer entries, power of two, range 2..256.
REQ-005 Parameter PARITY_ODD, default 0; 0 = even parity, 1 = odd parity; used only under UART_TX_PARITY_EN.
REQ-006 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 Port d_in, input, DATA_BITS bits: parallel data word to enqueue.
REQ-009 Port load, input, 1 bit: one-cycle write strobe; the caller supplies it already debounced and edge-detected.
REQ-010 Port tx_out, output, 1 bit: serial line, idle high.
REQ-011 Port tx_status, output, 1 bit: 1 while a frame is being shifted (FSM not in IDLE).
REQ-012 Port fifo_full, output, 1 bit: buffer holds FIFO_DEPTH entries.
REQ-013 Port fifo_empty, output, 1 bit: buffer holds 0 entries.
REQ-014 Port fifo_count, output, clog2(FIFO_DEPTH)+1 bits: current occupancy.
REQ-015 Port overflow, output, 1 bit: sticky flag, set when a load is dropped.

Function
REQ-016 The block SHALL write d_in into the FIFO on any edge where load=1 and fifo_full=0.
REQ-017 A load with fifo_full=1 SHALL be dropped and SHALL set overflow, even if a pop occurs in the same cycle.
REQ-018 The FSM states SHALL be IDLE, START, DATA, PARITY (under the macro only) and STOP.
- Every state except IDLE SHALL last exactly CLKS_PER_BIT clocks per bit, timed by an internal baud counter.
- No separate baud-clock domain is permitted.
REQ-019 In IDLE with fifo_empty=0, the FSM SHALL pop the head entry and enter START on the same edge.
- Consequence: with the FIFO empty and idle, tx_out falls on the edge after the edge that sampled load.
REQ-020 tx_out SHALL be: 0 in START; data bits LSB first in DATA; the parity bit in PARITY; 1 in STOP and IDLE.
REQ-021 STOP SHALL last STOP_BITS×CLKS_PER_BIT clocks.
- At its end, if fifo_empty=0, the FSM SHALL pop and go directly to START with no idle cycle.
- Otherwise it SHALL return to IDLE.
REQ-022 A push and a pop on the same edge SHALL leave fifo_count unchanged; count SHALL never wrap.
- Read and write pointers wrap modulo FIFO_DEPTH.
REQ-023 A load while the FSM is busy SHALL NOT disturb the frame in flight.
REQ-024 All outputs SHALL be registered; tx_out SHALL be glitch-free.

Reset
REQ-025 On rst=1 at a clock edge, the block SHALL apply the following, regardless of state or any frame in progress:
- tx_out=1, tx_status=0
- FSM to IDLE, baud counter to 0
- FIFO flushed: fifo_count=0, fifo_empty=1, fifo_full=0
- overflow=0
REQ-026 A load coincident with rst=1 SHALL be ignored.

Configuration
REQ-027 With macro UART_TX_PARITY_EN defined:
- PARITY is inserted between DATA and STOP.
- The parity bit = XOR of the data bits, inverted when PARITY_ODD=1.
- Frame length = (2+DATA_BITS+STOP_BITS)×CLKS_PER_BIT clocks.
REQ-028 Without UART_TX_PARITY_EN:
- No PARITY state or parity logic is present.
- PARITY_ODD is ignored.
- Frame length = (1+DATA_BITS+STOP_BITS)×CLKS_PER_BIT clocks.

Verification (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4 unless stated)
REQ-029 Single frame: after reset, load 0x55 for one cycle.
- tx_out=0 for 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, then 1 for 4 clocks.
- tx_status=1 for exactly 40 clocks.
REQ-030 Back-to-back with overflow: load 0x01..0x06 on six consecutive cycles while idle.
- 0x01..0x05 accepted; 0x06 dropped; overflow=1; fifo_full=1 after the fifth load.
- Five frames sent contiguously over 200 clocks with no idle gap; fifo_empty=1 at the end.
REQ-031 Parity (macro on, PARITY_ODD=0): load 0x07 -> parity bit=1 and frame = 44 clocks.
- With PARITY_ODD=1 the parity bit=0.
REQ-032 Reset mid-operation: assert rst for 1 cycle at clock 10 of a frame, with 2 entries queued.
- Next cycle: tx_out=1, tx_status=0, fifo_count=0.
- No further frame is sent.
REQ-033 Alternate frame format: DATA_BITS=7, STOP_BITS=2, macro off; load 0x41.
- Bits 0,1,0,0,0,0,0,1 then 1,1.
- Frame = 40 clocks.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small synchronous FIFO.
//
// Words written with `load` are queued and then sent one at a time in this frame order:
// start bit, DATA_BITS data bits LSB first, an optional parity bit, then STOP_BITS stop
// bits. When the queue still holds a word at the end of a stop period, the next frame
// starts on the following clock with no idle gap. Every output comes straight from a
// flop, so tx_out is glitch-free.
//
// Build option:
//   UART_TX_PARITY_EN - when defined, a parity bit goes between the data bits and the stop
//                       bits. It is the XOR of the data bits, inverted when PARITY_ODD != 0.
//                       When undefined, no parity logic is built and PARITY_ODD is unused.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (2..65535)
//   DATA_BITS     data bits per frame (5..9)
//   STOP_BITS     stop bits per frame (1 or 2)
//   FIFO_DEPTH    queue entries, power of two (2..256)
//   PARITY_ODD    0 = even parity, 1 = odd parity (only with UART_TX_PARITY_EN)
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset; flushes the queue and aborts any frame
//   d_in        word to enqueue
//   load        one-cycle write strobe; dropped when the queue is full
//   tx_out      serial line, idle high
//   tx_status   1 while a frame is being shifted
//   fifo_full   queue holds FIFO_DEPTH entries
//   fifo_empty  queue holds no entries
//   fifo_count  current queue occupancy
//   overflow    sticky; set when a load is dropped, cleared only by reset

module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_BITS-1:0]        d_in,
    input  logic                        load,
    output logic                        tx_out,
    output logic                        tx_status,
    output logic                        fifo_full,
    output logic                        fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS);

    // Reject illegal configurations at elaboration time.
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : gen_bad_clks_per_bit
        $error("uart_tx_fifo: CLKS_PER_BIT must be 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gen_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (1 << AW) != FIFO_DEPTH) begin : gen_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two in 2..256");
    end
    if (PARITY_ODD > 1) begin : gen_bad_parity_odd
        $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    // ------------------------------------------------------------------ state
    state_e               state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [IW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 status_q, status_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 ovf_q, ovf_d;

    logic                 push;
    logic                 pop;
    logic                 baud_tick;
    logic                 bit_last;
    logic                 stop_last;
    logic [DATA_BITS-1:0] head;

    assign head      = mem_q[rd_ptr_q];
    assign baud_tick = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign bit_last  = (bit_q == IW'(DATA_BITS - 1));
    assign stop_last = (stop_q == 1'(STOP_BITS - 1));

    // A load is accepted only against the registered full flag, so a pop on the same edge
    // cannot rescue a load that arrives while full.
    assign push = load && !full_q;

    // ------------------------------------------------------------ transmitter
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        pop     = 1'b0;

        // Every non-idle state is timed by the same free-running bit-period counter.
        if (state_q != StIdle) begin
            baud_d = baud_tick ? '0 : baud_q + BW'(1);
        end

        case (state_q)
            StIdle: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    state_d = StStart;
                    baud_d  = '0;
                end
            end
            StStart: begin
                if (baud_tick) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (baud_tick) begin
                    if (bit_last) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                        stop_d  = 1'b0;
                    end else begin
                        bit_d   = bit_q + IW'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (baud_tick) begin
                    state_d = StStop;
                    stop_d  = 1'b0;
                end
            end
`endif
            StStop: begin
                if (baud_tick) begin
                    if (!stop_last) begin
                        stop_d = 1'b1;
                    end else if (!empty_q) begin
                        // Chain straight into the next frame.
                        pop     = 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (pop) begin
            shift_d = head;
`ifdef UART_TX_PARITY_EN
            par_d   = (^head) ^ (PARITY_ODD != 0);
`endif
        end

        // The line level is decoded from the next state and then registered.
        case (state_d)
            StIdle:   tx_d = 1'b1;
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = par_d;
`endif
            StStop:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
        status_d = (state_d != StIdle);
    end

    // ------------------------------------------------------------------- fifo
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(FIFO_DEPTH));
        empty_d = (count_d == '0);
        ovf_d   = ovf_q || (load && full_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            status_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            status_q <= status_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= d_in;
        end
    end

    assign tx_out     = tx_q;
    assign tx_status  = status_q;
    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-and-frame-time reference model checked every cycle,
// plus hand-computed waveform expectations for the single-frame, back-to-back/overflow,
// mid-frame reset and 7-bit/2-stop cases, followed by randomized traffic.

module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DB    = 8;
    localparam int SB    = 1;
    localparam int DEPTH = 4;
    localparam bit PODD  = 1'b0;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FLEN     = (1 + PB + DB + SB) * CPB;
    localparam int ALT_FLEN = (1 + PB + 7 + 2) * CPB;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] d_in;
    logic       tx_out, tx_status, fifo_full, fifo_empty, overflow;
    logic [2:0] fifo_count;

    logic       alt_load;
    logic [6:0] alt_din;
    logic       alt_tx, alt_status, alt_full, alt_empty, alt_ovf;
    logic [2:0] alt_count;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .STOP_BITS   (SB),
        .FIFO_DEPTH  (DEPTH),
        .PARITY_ODD  (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .load      (load),
        .tx_out    (tx_out),
        .tx_status (tx_status),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (7),
        .STOP_BITS   (2),
        .FIFO_DEPTH  (DEPTH),
        .PARITY_ODD  (1)
    ) dut_alt (
        .clk       (clk),
        .rst       (rst),
        .d_in      (alt_din),
        .load      (alt_load),
        .tx_out    (alt_tx),
        .tx_status (alt_status),
        .fifo_full (alt_full),
        .fifo_empty(alt_empty),
        .fifo_count(alt_count),
        .overflow  (alt_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------- reference model
    // The queue holds accepted words; a busy transmitter is described only by the word in
    // flight and the clock index within its frame.
    logic [7:0] mq[$];
    bit         m_valid = 1'b0;
    bit         m_busy  = 1'b0;
    int         m_t     = 0;
    logic [7:0] m_cur   = '0;
    bit         m_ovf   = 1'b0;
    bit         m_full_before;

    function automatic logic exp_bit(input logic [7:0] cur, input int t);
        int k;
        k = t / CPB;
        if (k == 0) return 1'b0;
        if (k <= DB) return cur[k-1];
        if (PB == 1 && k == DB + 1) return (^cur) ^ PODD;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_busy  = 1'b0;
            m_t     = 0;
            m_ovf   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_full_before = (mq.size() == DEPTH);
            if (m_busy && m_t == FLEN - 1) m_busy = 1'b0;
            else if (m_busy) m_t++;
            if (!m_busy && mq.size() > 0) begin
                m_cur  = mq.pop_front();
                m_busy = 1'b1;
                m_t    = 0;
            end
            if (load) begin
                if (m_full_before) m_ovf = 1'b1;
                else mq.push_back(d_in);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_tx_out", tx_out, m_busy ? exp_bit(m_cur, m_t) : 1'b1);
            chk("model_tx_status", tx_status, m_busy);
            chk("model_fifo_count", fifo_count, mq.size());
            chk("model_fifo_empty", fifo_empty, mq.size() == 0);
            chk("model_fifo_full", fifo_full, mq.size() == DEPTH);
            chk("model_overflow", overflow, m_ovf);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog at %0t: got no finish expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        logic [10:0] exp_single;
        logic [10:0] exp_alt;
        logic [7:0]  single_word;
        int          highs;
        int          n;
        int          dens;

`ifdef UART_TX_PARITY_EN
        single_word = 8'h07;
        exp_single  = 11'b11000001110;  // start, 1110_0000, parity 1, stop
        exp_alt     = 11'b11110000010;  // start, 100_0001, odd parity 1, stop x2
`else
        single_word = 8'h55;
        exp_single  = 11'b01010101010;  // start, 1010_1010, stop
        exp_alt     = 11'b01110000010;  // start, 100_0001, stop x2
`endif

        rst = 1'b1; load = 1'b0; d_in = '0; alt_load = 1'b0; alt_din = '0;
        tick();
        tick();
        chk("rst_tx_out", tx_out, 1);
        chk("rst_tx_status", tx_status, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_fifo_empty", fifo_empty, 1);
        chk("rst_fifo_full", fifo_full, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;
        tick();

        // Single frame; the line falls one edge after the load is sampled.
        d_in = single_word; load = 1'b1;
        tick();
        load = 1'b0;
        chk("single_line_still_idle", tx_out, 1);
        chk("single_count_one", fifo_count, 1);
        tick();
        highs = 0;
        for (int i = 0; i < FLEN; i++) begin
            chk("single_bit", tx_out, exp_single[i / CPB]);
            highs += int'(tx_status);
            tick();
        end
        chk("single_status_len", highs, FLEN);
        chk("single_idle_after", tx_status, 0);
        chk("single_empty_after", fifo_empty, 1);

        // 7 data bits, 2 stop bits.
        alt_din = 7'h41; alt_load = 1'b1;
        tick();
        alt_load = 1'b0;
        tick();
        highs = 0;
        for (int i = 0; i < ALT_FLEN; i++) begin
            chk("alt_bit", alt_tx, exp_alt[i / CPB]);
            highs += int'(alt_status);
            tick();
        end
        chk("alt_status_len", highs, ALT_FLEN);
        chk("alt_idle_after", alt_status, 0);
        chk("alt_empty_after", alt_empty, 1);
        chk("alt_full_after", alt_full, 0);
        chk("alt_count_after", alt_count, 0);
        chk("alt_overflow", alt_ovf, 0);

        // Six back-to-back loads into a depth-4 queue; the first is popped at once.
        for (int v = 1; v <= 6; v++) begin
            d_in = 8'(v); load = 1'b1;
            tick();
            if (v == 4) chk("b2b_not_full_at_4", fifo_full, 0);
            if (v == 5) chk("b2b_full_at_5", fifo_full, 1);
        end
        load = 1'b0;
        chk("b2b_overflow", overflow, 1);
        chk("b2b_count_full", fifo_count, 4);
        n = 0;
        while (tx_status && n < 400) begin
            n++;
            tick();
        end
        chk("b2b_busy_len", n, 5 * FLEN - 4);
        chk("b2b_empty_end", fifo_empty, 1);
        chk("b2b_overflow_sticky", overflow, 1);

        // Reset at clock 10 of a frame with two words still queued.
        d_in = 8'hA1; load = 1'b1;
        tick();
        d_in = 8'hB2;
        tick();
        d_in = 8'hC3;
        tick();
        load = 1'b0;
        chk("midrst_queued", fifo_count, 2);
        repeat (7) tick();
        chk("midrst_busy_before", tx_status, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_tx_out", tx_out, 1);
        chk("midrst_tx_status", tx_status, 0);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_empty", fifo_empty, 1);
        chk("midrst_overflow", overflow, 0);
        highs = 0;
        repeat (100) begin
            highs += int'(tx_status);
            tick();
        end
        chk("midrst_no_frame", highs, 0);

        // Random traffic at several load densities with rare resets.
        for (int seg = 0; seg < 6; seg++) begin
            dens = (seg % 3 == 0) ? 2 : ((seg % 3 == 1) ? 20 : 60);
            for (int c = 0; c < 500; c++) begin
                load = ($urandom_range(0, dens) == 0);
                d_in = 8'($urandom);
                rst  = ($urandom_range(0, 399) == 0);
                tick();
            end
        end
        load = 1'b0;
        rst  = 1'b0;
        n = 0;
        while ((!fifo_empty || tx_status) && n < 2000) begin
            n++;
            tick();
        end
        chk("drain_done", fifo_empty && !tx_status, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
